// File: rtl/ser_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding,
// line levels and the default word width.
package ser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ser_tx_shift_reg_pl.sv
// Parallel-load, enable-gated right shift register (zero fill, LSB out),
// assembled from single-bit enabled D flip-flop cells.
module dff_en (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module shift_reg_pl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // One extra zero bit above the MSB supplies the shift-in value.
  logic [WIDTH:0] q_ext;
  assign q_ext = {1'b0, q};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bit_d;
      assign bit_d = load ? d[gi] : q_ext[gi+1];

      dff_en u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (load | shift),
        .d       (bit_d),
        .q       (q[gi])
      );
    end
  endgenerate

endmodule

// File: rtl/ser_tx.sv
// Frame transmitter: start bit, WIDTH data bits LSB first, stop bit.
// The state machine advances only on en-qualified edges; acceptance ignores en.
module ser_tx
  import ser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             valid,
  input  logic [WIDTH-1:0] d_in,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             tx_reg, tx_next;
  logic             done_reg, done_next;
  logic             load, shift;
  logic [WIDTH-1:0] sr_q;

  shift_reg_pl #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .d       (d_in),
    .q       (sr_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_reg   <= LINE_IDLE;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      tx_reg   <= tx_next;
      done_reg <= done_next;
    end
  end

  // tx_next carries the bit of the state being entered so tx is registered.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tx_next    = tx_reg;
    done_next  = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        tx_next = LINE_IDLE;
        if (valid) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = START;
          tx_next    = START_BIT;
        end
      end
      START: begin
        if (en) begin
          state_next = DATA;
          tx_next    = sr_q[0];
        end
      end
      DATA: begin
        if (en) begin
          shift    = 1'b1;
          cnt_next = cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state_next = STOP;
            tx_next    = STOP_BIT;
          end else begin
            tx_next = sr_q[1];
          end
        end
      end
      STOP: begin
        if (en) begin
          state_next = IDLE;
          tx_next    = LINE_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);
  assign tx    = tx_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_ser_tx.sv
// Bench for ser_tx: directed vector table, hand-written corner sequences and
// random traffic, all checked against a frame-level reference model.
module tb_ser_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] d_in = '0;
  logic         ready, tx, busy, done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ser_tx #(.WIDTH(W), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .valid   (valid),
    .d_in    (d_in),
    .ready   (ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of W+2 line bits; an accepted word
  // walks through that list one position per enabled edge.
  int           m_pos;
  logic [W+1:0] m_bits;
  logic         m_done;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pos  <= -1;
      m_bits <= '1;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_pos < 0) begin
        if (valid) begin
          m_pos  <= 0;
          m_bits <= {1'b1, d_in, 1'b0};
          $display("accept word %02h at %0t", d_in, $time);
        end
      end else if (en) begin
        if (m_pos == W + 1) begin
          m_pos  <= -1;
          m_done <= 1'b1;
        end else begin
          m_pos <= m_pos + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_tx", {31'd0, tx}, {31'd0, (m_pos < 0) ? 1'b1 : m_bits[m_pos]});
      chk("model_busy", {31'd0, busy}, {31'd0, m_pos >= 0});
      chk("model_ready", {31'd0, ready}, {31'd0, m_pos < 0});
      chk("model_done", {31'd0, done}, {31'd0, m_done});
    end
  end

  typedef struct {
    logic         valid;
    logic         en;
    logic [W-1:0] d;
    logic         exp_tx;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  vec_t       vecs[12];
  logic [0:11] tx_seq   = 12'b0101_0010_1111;
  logic [0:11] busy_seq = 12'b1111_1111_1100;
  logic [0:11] done_seq = 12'b0000_0000_0010;
  logic [0:9]  b2b_seq  = 10'b0_00000001_1;

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int   en_edges;
    bit   seen;
    logic t0;

    for (int i = 0; i < 12; i++) begin
      vecs[i].valid    = (i == 0);
      vecs[i].en       = 1'b1;
      vecs[i].d        = (i == 0) ? 8'hA5 : 8'h00;
      vecs[i].exp_tx   = tx_seq[i];
      vecs[i].exp_busy = busy_seq[i];
      vecs[i].exp_done = done_seq[i];
    end

    // 1. reset
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk_en = 1'b1;

    // 2. single frame 0xA5, en tied high
    for (int i = 0; i < 12; i++) begin
      valid = vecs[i].valid;
      en    = vecs[i].en;
      d_in  = vecs[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d_tx", i), {31'd0, tx}, {31'd0, vecs[i].exp_tx});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
    end

    // 3. pause for 7 cycles in DATA; frame still takes 10 enabled edges
    valid = 1'b1; d_in = 8'h3C; en = 1'b1;
    @(negedge clk);
    valid = 1'b0; d_in = 8'h00;
    en_edges = 0;
    repeat (3) begin
      @(negedge clk);
      en_edges++;
    end
    t0 = tx;
    en = 1'b0;
    repeat (7) begin
      @(negedge clk);
      chk("pause_tx", {31'd0, tx}, {31'd0, t0});
      chk("pause_busy", {31'd0, busy}, 32'd1);
    end
    en = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      en_edges++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("pause_done_seen", {31'd0, seen}, 32'd1);
    chk("pause_en_edges", en_edges, 32'd10);

    // 4. valid while busy is ignored
    valid = 1'b1; d_in = 8'h5A;
    @(negedge clk);
    d_in = 8'hFF;
    repeat (5) begin
      @(negedge clk);
      chk("busy_ready", {31'd0, ready}, 32'd0);
    end
    valid = 1'b0;
    wait_done("busy_done_seen");
    @(negedge clk);
    chk("busy_no_refire", {31'd0, busy}, 32'd0);
    chk("busy_idle_tx", {31'd0, tx}, 32'd1);

    // 5. back-to-back 0x01 then 0x80, second valid on the done cycle
    valid = 1'b1; d_in = 8'h01;
    @(negedge clk);
    valid = 1'b0;
    wait_done("b2b_done_seen");
    chk("b2b_done_ready", {31'd0, ready}, 32'd1);
    chk("b2b_gap_tx", {31'd0, tx}, 32'd1);
    valid = 1'b1; d_in = 8'h80;
    @(negedge clk);
    valid = 1'b0; d_in = 8'h00;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("b2b_bit%0d", i), {31'd0, tx}, {31'd0, b2b_seq[i]});
      @(negedge clk);
    end
    chk("b2b_done2", {31'd0, done}, 32'd1);

    // 6. asynchronous reset during DATA bit 4 of 0xF0
    valid = 1'b1; d_in = 8'hF0;
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("mid_ready", {31'd0, ready}, 32'd1);
      chk("mid_no_done", {31'd0, done}, 32'd0);
    end

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      en    = ($urandom_range(0, 9) < 7);
      valid = ($urandom_range(0, 3) == 0);
      d_in  = W'($urandom);
      @(negedge clk);
    end
    valid = 1'b0; en = 1'b1;
    repeat (15) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
